matrix_capture: RTL and testbench

- Receive-side counterpart of the LED-matrix row-scan driver.
- Samples the scanned column drives (red, green) and the active-low row sink, then rebuilds the full 8x8 red and green frames.
- Publishes each complete frame with a one-cycle valid pulse, and counts frames and protocol errors.
- Used for self-check loopback of the game display in simulation and on-board (GPIO_0 driver pins looped back to an input header).

---
 rtl/matrix_capture.sv | 144 ++++++++++++++
 tb/tb_matrix_capture.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_capture.sv
// rtl/matrix_capture.sv - rebuilds 8x8 red/green frames from a sampled LED row scan
//
// Purpose: receive side of the LED-matrix row-scan loopback. Each cycle the
// active-low row sink is classified as blanking, a single lit row, or a
// protocol error. A lit row that has held steady for SETTLE_CYCLES samples is
// written into shadow buffers. Once all eight rows have been seen, the shadow
// contents are published with a one-cycle frame_valid pulse.
//
// Ports:
//   clock         system clock (the scan driver's divided clock)
//   reset         synchronous, active-low
//   red_driver    red column drive, bit c = column c, active-high
//   green_driver  green column drive, active-high
//   row_sink      row select, active-low one-hot
//   red_frame     published red frame, red_frame[r][c]
//   green_frame   published green frame
//   frame_valid   one-cycle pulse on each frame publish
//   frame_count   completed frames, wrapping
//   err_count     multi-row (invalid) samples, saturating
//   sync_lost     high while no row has been accepted for TIMEOUT_CYCLES
module matrix_capture #(
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      red_driver,
  input  logic [7:0]      green_driver,
  input  logic [7:0]      row_sink,
  output logic [7:0][7:0] red_frame,
  output logic [7:0][7:0] green_frame,
  output logic            frame_valid,
  output logic [7:0]      frame_count,
  output logic [7:0]      err_count,
  output logic            sync_lost
);

  localparam logic [3:0]  SETTLE  = 4'(SETTLE_CYCLES);
  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  logic [7:0]      prev_sink, prev_red, prev_green;
  logic [3:0]      run, run_next;
  logic [15:0]     idle_cnt, idle_next;
  logic [7:0]      seen, seen_next;
  logic [7:0][7:0] shadow_red, shadow_green;
  logic [7:0][7:0] shadow_red_next, shadow_green_next;
  logic [7:0]      row_low;
  logic [2:0]      row_idx;
  logic            is_idle, is_valid, is_invalid, same, accept, complete, timeout_hit;

  assign row_low    = ~row_sink;
  assign is_idle    = (row_sink == 8'hFF);
  // Exactly one low bit: clearing the lowest set bit of row_low leaves nothing.
  assign is_valid   = !is_idle && ((row_low & (row_low - 8'd1)) == 8'd0);
  assign is_invalid = !is_idle && !is_valid;
  assign same       = (row_sink == prev_sink) && (red_driver == prev_red) &&
                      (green_driver == prev_green);

  always_comb begin
    row_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (row_low[i]) row_idx = 3'(i);
    end
  end

  // run is zero after any non-VALID sample, so a non-zero run also means the
  // previous sample was VALID and may be extended.
  always_comb begin
    run_next = 4'd0;
    if (is_valid) begin
      if (same && run != 4'd0) run_next = (run == 4'hF) ? 4'hF : run + 4'd1;
      else                     run_next = 4'd1;
    end
  end

  assign accept = is_valid && (run_next >= SETTLE);

  always_comb begin
    shadow_red_next   = shadow_red;
    shadow_green_next = shadow_green;
    seen_next         = seen;
    if (accept) begin
      shadow_red_next[row_idx]   = red_driver;
      shadow_green_next[row_idx] = green_driver;
      seen_next[row_idx]         = 1'b1;
    end
  end

  // Publishing uses the *_next shadows so the row accepted this cycle is included.
  assign complete = accept && (seen_next == 8'hFF);

  always_comb begin
    if (accept)                idle_next = 16'd0;
    else if (idle_cnt == TIMEOUT) idle_next = TIMEOUT;
    else                       idle_next = idle_cnt + 16'd1;
  end

  assign timeout_hit = (idle_next == TIMEOUT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_sink    <= 8'hFF;
      prev_red     <= 8'd0;
      prev_green   <= 8'd0;
      run          <= 4'd0;
      idle_cnt     <= 16'd0;
      seen         <= 8'd0;
      shadow_red   <= '0;
      shadow_green <= '0;
      red_frame    <= '0;
      green_frame  <= '0;
      frame_valid  <= 1'b0;
      frame_count  <= 8'd0;
      err_count    <= 8'd0;
      sync_lost    <= 1'b0;
    end else begin
      prev_sink    <= row_sink;
      prev_red     <= red_driver;
      prev_green   <= green_driver;
      run          <= run_next;
      idle_cnt     <= idle_next;
      shadow_red   <= shadow_red_next;
      shadow_green <= shadow_green_next;
      frame_valid  <= complete;

      if (complete) begin
        red_frame   <= shadow_red_next;
        green_frame <= shadow_green_next;
        frame_count <= frame_count + 8'd1;
        seen        <= 8'd0;
      end else if (timeout_hit) begin
        seen <= 8'd0;
      end else begin
        seen <= seen_next;
      end

      if (is_invalid && err_count != 8'hFF) err_count <= err_count + 8'd1;

      if (accept)           sync_lost <= 1'b0;
      else if (timeout_hit) sync_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_capture.sv
// tb/tb_matrix_capture.sv - directed scoreboard bench for matrix_capture
module tb_matrix_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_reset, b_reset;
  logic [7:0]      a_red_in, a_green_in, a_sink;
  logic [7:0]      b_red_in, b_green_in, b_sink;
  logic [7:0][7:0] a_red, a_green, b_red, b_green;
  logic            a_valid, b_valid, a_sync, b_sync;
  logic [7:0]      a_count, a_err, b_count, b_err;

  matrix_capture #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(64)) dut_a (
    .clock(clk), .reset(a_reset), .red_driver(a_red_in), .green_driver(a_green_in),
    .row_sink(a_sink), .red_frame(a_red), .green_frame(a_green), .frame_valid(a_valid),
    .frame_count(a_count), .err_count(a_err), .sync_lost(a_sync));

  matrix_capture #(.SETTLE_CYCLES(3), .TIMEOUT_CYCLES(64)) dut_b (
    .clock(clk), .reset(b_reset), .red_driver(b_red_in), .green_driver(b_green_in),
    .row_sink(b_sink), .red_frame(b_red), .green_frame(b_green), .frame_valid(b_valid),
    .frame_count(b_count), .err_count(b_err), .sync_lost(b_sync));

  typedef struct {
    logic [7:0][7:0] red;
    logic [7:0][7:0] green;
    logic [7:0]      count;
  } frame_t;

  frame_t qa[$];
  frame_t qb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model for instance A (SETTLE_CYCLES=1): every lit row is accepted.
  logic [7:0][7:0] m_red   = '0;
  logic [7:0][7:0] m_green = '0;
  logic [7:0]      m_seen  = 8'd0;
  logic [7:0]      m_count = 8'd0;
  logic [7:0]      m_err   = 8'd0;
  int              m_idle  = 0;
  logic            m_sync  = 1'b0;
  logic            m_fire  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] row(input int r);
    logic [7:0] one;
    one = 8'h01 << r;
    return ~one;
  endfunction

  task automatic step_a(input logic [7:0] sink, input logic [7:0] red, input logic [7:0] green);
    logic [7:0] low;
    int         r;
    logic       acc;
    frame_t     f;
    a_sink = sink; a_red_in = red; a_green_in = green;
    low = ~sink; acc = 1'b0; m_fire = 1'b0; r = 0;
    if ($countones(low) == 1) begin
      acc = 1'b1;
      for (int i = 0; i < 8; i++) if (low[i]) r = i;
      m_red[r] = red; m_green[r] = green; m_seen[r] = 1'b1;
      if (m_seen == 8'hFF) begin
        m_count = m_count + 8'd1;
        f.red = m_red; f.green = m_green; f.count = m_count;
        qa.push_back(f);
        m_seen = 8'd0; m_fire = 1'b1;
      end
    end else if ($countones(low) > 1) begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end
    if (acc) begin
      m_idle = 0; m_sync = 1'b0;
    end else if (m_idle < 64) begin
      m_idle++;
      if (m_idle == 64) begin m_sync = 1'b1; m_seen = 8'd0; end
    end
    @(posedge clk); #1;
    check("a_frame_valid", a_valid, m_fire);
    check("a_frame_count", a_count, m_count);
    check("a_err_count", a_err, m_err);
    check("a_sync_lost", a_sync, m_sync);
  endtask

  task automatic step_b(input logic [7:0] sink, input logic [7:0] red, input logic [7:0] green,
                        input logic exp_valid);
    b_sink = sink; b_red_in = red; b_green_in = green;
    @(posedge clk); #1;
    check("b_frame_valid", b_valid, exp_valid);
  endtask

  always @(negedge clk) begin
    frame_t f;
    if (a_valid === 1'b1) begin
      check("a_frame_expected", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        f = qa.pop_front();
        check("a_red_frame", a_red, f.red);
        check("a_green_frame", a_green, f.green);
        check("a_frame_count_at_valid", a_count, f.count);
      end
    end
    if (b_valid === 1'b1) begin
      check("b_frame_expected", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        f = qb.pop_front();
        check("b_red_frame", b_red, f.red);
        check("b_green_frame", b_green, f.green);
        check("b_frame_count_at_valid", b_count, f.count);
      end
    end
  end

  initial begin
    frame_t fb;
    a_reset = 1'b0; a_sink = 8'hFE; a_red_in = 8'h5A; a_green_in = 8'hA5;
    b_reset = 1'b0; b_sink = 8'hFF; b_red_in = 8'h00; b_green_in = 8'h00;

    // Reset held with a lit row: nothing may be accepted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_frame_valid", a_valid, 0);
    check("rst_frame_count", a_count, 0);
    check("rst_err_count", a_err, 0);
    check("rst_sync_lost", a_sync, 0);
    check("rst_red_frame", a_red, 0);
    check("rst_green_frame", a_green, 0);

    // Release: row 0 accepted on the first edge, then rows 1..7.
    a_reset = 1'b1;
    step_a(8'hFE, 8'h5A, 8'hA5);
    for (int r = 1; r < 8; r++) step_a(row(r), 8'(r), 8'hF0 - 8'(r));
    check("t2_red_row0", a_red[0], 8'h5A);
    check("t2_red_row3", a_red[3], 8'h03);
    check("t2_green_row3", a_green[3], 8'hED);
    check("t2_count", a_count, 1);
    step_a(8'hFF, 8'h00, 8'h00);

    // Re-accepted row: latest data wins, single publish.
    for (int r = 0; r < 7; r++) step_a(row(r), 8'h10 + 8'(r), ~8'(r));
    step_a(row(2), 8'hAA, 8'h55);
    step_a(row(7), 8'h77, 8'h88);
    check("t3_red_row2", a_red[2], 8'hAA);
    check("t3_count", a_count, 2);

    // Invalid samples mid-scan: counted, partial frame kept.
    for (int r = 0; r < 4; r++) step_a(row(r), 8'h20 + 8'(r), 8'h00);
    repeat (3) step_a(8'hFC, 8'hFF, 8'hFF);
    check("t4_err3", a_err, 3);
    for (int r = 4; r < 8; r++) step_a(row(r), 8'h20 + 8'(r), 8'h00);
    check("t4_count", a_count, 3);
    repeat (300) step_a(8'hFC, 8'h00, 8'h00);
    check("t4_err_sat", a_err, 8'hFF);
    check("t4_sync_after_invalid", a_sync, 1);
    check("t4_frame_kept", a_red[3], 8'h23);

    // Timeout discards a partial frame; rescan order exposes stale rows.
    for (int r = 0; r < 5; r++) step_a(row(r), 8'h30 + 8'(r), 8'h0F);
    check("t6_sync_cleared", a_sync, 0);
    repeat (63) step_a(8'hFF, 8'h00, 8'h00);
    check("t6_sync_before_limit", a_sync, 0);
    step_a(8'hFF, 8'h00, 8'h00);
    check("t6_sync_at_limit", a_sync, 1);
    check("t6_frame_kept", a_red[3], 8'h23);
    step_a(row(5), 8'h45, 8'h01);
    check("t6_sync_after_accept", a_sync, 0);
    step_a(row(6), 8'h46, 8'h01);
    step_a(row(7), 8'h47, 8'h01);
    for (int r = 0; r < 5; r++) step_a(row(r), 8'h40 + 8'(r), 8'h01);
    check("t6_count", a_count, 4);
    check("t6_red_row0", a_red[0], 8'h40);
    check("t6_red_row7", a_red[7], 8'h47);

    // Settle of 3: two-cycle rows never accept, three-cycle rows do.
    step_b(8'hFF, 8'h00, 8'h00, 1'b0);
    b_reset = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 2; k++) step_b(row(r), 8'h50 + 8'(r), 8'h60 + 8'(r), 1'b0);
    check("t5_no_frame", b_count, 0);
    for (int r = 0; r < 8; r++) begin
      fb.red[r] = 8'h50 + 8'(r); fb.green[r] = 8'h60 + 8'(r);
    end
    fb.count = 8'd1;
    qb.push_back(fb);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 3; k++)
        step_b(row(r), 8'h50 + 8'(r), 8'h60 + 8'(r), (r == 7 && k == 2));
    check("t5_count", b_count, 1);
    check("t5_red_row5", b_red[5], 8'h55);
    step_b(8'hFF, 8'h00, 8'h00, 1'b0);

    step_a(8'hFF, 8'h00, 8'h00);
    @(posedge clk); #1;
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
